// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_LD,
      CLS_ST,
      CLS_BEQ,
      CLS_JMP,
      CLS_HALT,
      CLS_ILLEGAL
   } op_class_t;

   localparam logic [3:0] OP_LD   = 4'b1000;
   localparam logic [3:0] OP_ST   = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;
   localparam logic [3:0] OP_JMP  = 4'b1011;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;

   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/instr_decode.sv
// Combinational field extraction and opcode classification of the latched instruction.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  rd,
   output logic [2:0]  rs1,
   output logic [2:0]  rs2,
   output logic [15:0] imm_sext,
   output logic [15:0] jmp_tgt,
   output op_class_t   op_class,
   output logic [2:0]  alu_sel
);

   logic [3:0] opcode;

   assign opcode   = ir[15:12];
   assign rd       = ir[11:9];
   assign rs1      = ir[8:6];
   assign rs2      = ir[5:3];
   assign imm_sext = {{10{ir[5]}}, ir[5:0]};
   assign jmp_tgt  = {4'h0, ir[11:0]};

   // Classify the opcode and pick the ALU operation it needs
   always_comb begin
      op_class = CLS_ILLEGAL;
      alu_sel  = ALU_ADD;
      if (!opcode[3]) begin
         op_class = CLS_RTYPE;
         alu_sel  = opcode[2:0];
      end else begin
         case (opcode)
            OP_LD:   op_class = CLS_LD;
            OP_ST:   op_class = CLS_ST;
            OP_BEQ: begin
               op_class = CLS_BEQ;
               alu_sel  = ALU_SUB;
            end
            OP_JMP:  op_class = CLS_JMP;
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer with instruction register.
module ctrl_unit
   import ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] instr_in,
   input  logic        mem_ready,
   input  logic        zf,
   output logic [15:0] ir_q,
   output logic [2:0]  rd,
   output logic [2:0]  rs1,
   output logic [2:0]  rs2,
   output logic [15:0] imm_sext,
   output logic [15:0] jmp_tgt,
   output logic [2:0]  alu_sel,
   output logic        alu_src_b,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        addr_sel,
   output logic        mem_re,
   output logic        mem_we,
   output logic        reg_we,
   output logic        wb_sel,
   output logic        illegal,
   output logic        halted
);

   state_t    state;
   op_class_t op_class;

   instr_decode u_decode (
      .ir       (ir_q),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .imm_sext (imm_sext),
      .jmp_tgt  (jmp_tgt),
      .op_class (op_class),
      .alu_sel  (alu_sel)
   );

   // Operand select and writeback source follow the latched instruction, so they
   // stay stable across EXECUTE, MEM and WB.
   assign alu_src_b = (op_class == CLS_LD) || (op_class == CLS_ST);
   assign wb_sel    = (op_class == CLS_LD);
   assign halted    = (state == S_HALT);

   // Sequencer state and instruction register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         ir_q  <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_q  <= instr_in;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (op_class)
                  CLS_JMP, CLS_ILLEGAL: state <= S_FETCH;
                  CLS_HALT:             state <= S_HALT;
                  default:              state <= S_EXECUTE;
               endcase
            end
            S_EXECUTE: begin
               case (op_class)
                  CLS_RTYPE:    state <= S_WB;
                  CLS_LD, CLS_ST: state <= S_MEM;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (mem_ready) state <= (op_class == CLS_LD) ? S_WB : S_FETCH;
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Strobes and selects; held at zero while rst is high so a reset cycle never
   // issues a memory access or PC update, even from FETCH with mem_ready high.
   always_comb begin
      pc_we    = 1'b0;
      pc_sel   = PC_INC;
      addr_sel = 1'b0;
      mem_re   = 1'b0;
      mem_we   = 1'b0;
      reg_we   = 1'b0;
      illegal  = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_re = 1'b1;
               pc_we  = mem_ready;
            end
            S_DECODE: begin
               if (op_class == CLS_JMP) begin
                  pc_we  = 1'b1;
                  pc_sel = PC_JUMP;
               end
               illegal = (op_class == CLS_ILLEGAL);
            end
            S_EXECUTE: begin
               if (op_class == CLS_BEQ) begin
                  pc_sel = PC_BRANCH;
                  pc_we  = zf;
               end
            end
            S_MEM: begin
               addr_sel = 1'b1;
               mem_re   = (op_class == CLS_LD);
               mem_we   = (op_class == CLS_ST);
            end
            S_WB:    reg_we = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed table, corner sequences, randomized instruction stream.
module tb_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr_in;
   logic        mem_ready;
   logic        zf;
   logic [15:0] ir_q;
   logic [2:0]  rd, rs1, rs2;
   logic [15:0] imm_sext, jmp_tgt;
   logic [2:0]  alu_sel;
   logic        alu_src_b, pc_we, addr_sel, mem_re, mem_we, reg_we, wb_sel, illegal, halted;
   logic [1:0]  pc_sel;

   int checks = 0;
   int errors = 0;

   ctrl_unit dut (
      .clk       (clk),
      .rst       (rst),
      .instr_in  (instr_in),
      .mem_ready (mem_ready),
      .zf        (zf),
      .ir_q      (ir_q),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm_sext  (imm_sext),
      .jmp_tgt   (jmp_tgt),
      .alu_sel   (alu_sel),
      .alu_src_b (alu_src_b),
      .pc_we     (pc_we),
      .pc_sel    (pc_sel),
      .addr_sel  (addr_sel),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .reg_we    (reg_we),
      .wb_sel    (wb_sel),
      .illegal   (illegal),
      .halted    (halted)
   );

   always #5 clk = ~clk;

   // One instruction: stimulus plus expected per-instruction totals.
   // lat = cycles from first FETCH cycle to return to FETCH; counts are strobe-high cycles.
   typedef struct {
      logic [15:0] instr;
      logic        zf;
      int          f;      // FETCH stall cycles
      int          m;      // MEM stall cycles
      int          lat;
      int          re, we, rw, rl, pc, pj, pb, ill, ad;
      logic [2:0]  alu;
      logic        srcb;
      logic [2:0]  rd, rs1, rs2;
      logic [15:0] imm, jmp;
   } vec_t;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   // Reference expectations from the instruction set rules
   function automatic vec_t model(input logic [15:0] instr, input logic z, input int f, input int m);
      vec_t v;
      int   op;
      int   imm;
      op = int'(instr[15:12]);
      v.instr = instr; v.zf = z; v.f = f; v.m = m;
      v.re = f + 1; v.we = 0; v.rw = 0; v.rl = 0; v.pc = 1; v.pj = 0; v.pb = 0;
      v.ill = 0; v.ad = 0; v.alu = 3'd0; v.srcb = 1'b0;
      if (op < 8) begin
         v.lat = f + 4; v.rw = 1; v.alu = 3'(op % 8);
      end else if (op == 8) begin
         v.lat = f + 5 + m; v.re += m + 1; v.rw = 1; v.rl = 1; v.ad = m + 1; v.srcb = 1'b1;
      end else if (op == 9) begin
         v.lat = f + 4 + m; v.we = m + 1; v.ad = m + 1; v.srcb = 1'b1;
      end else if (op == 10) begin
         v.lat = f + 3; v.alu = 3'd1;
         if (z) begin v.pc = 2; v.pb = 1; end
      end else if (op == 11) begin
         v.lat = f + 2; v.pc = 2; v.pj = 1;
      end else begin
         v.lat = f + 2; v.ill = 1;
      end
      v.rd  = 3'((instr >> 9) % 8);
      v.rs1 = 3'((instr >> 6) % 8);
      v.rs2 = 3'((instr >> 3) % 8);
      imm = int'(instr % 16'd64);
      if (imm >= 32) imm -= 64;
      v.imm = 16'(imm);
      v.jmp = instr % 16'h1000;
      return v;
   endfunction

   // Run one instruction from FETCH back to FETCH and compare totals
   task automatic run_vec(input string tag, input vec_t v);
      int re = 0, we = 0, rw = 0, rl = 0, pc = 0, pj = 0, pb = 0, il = 0, ad = 0, hl = 0;
      int alu_bad = 0, srcb_bad = 0;
      logic [15:0] c_ir = '0, c_imm = '0, c_jmp = '0;
      logic [2:0]  c_rd = '0, c_rs1 = '0, c_rs2 = '0;
      bit is_mem;
      is_mem = (v.instr[15:12] == 4'h8) || (v.instr[15:12] == 4'h9);
      for (int i = 0; i < v.lat; i++) begin
         if (i < v.f) mem_ready = 1'b0;
         else if (i == v.f) mem_ready = 1'b1;
         else if (is_mem && i >= v.f + 3 && i < v.f + 3 + v.m) mem_ready = 1'b0;
         else if (is_mem && i == v.f + 3 + v.m) mem_ready = 1'b1;
         else mem_ready = 1'($urandom % 2);
         instr_in = (i == v.f) ? v.instr : 16'($urandom);
         zf = (i == v.f + 2) ? v.zf : 1'($urandom % 2);
         @(negedge clk);
         re += int'(mem_re); we += int'(mem_we); rw += int'(reg_we); pc += int'(pc_we);
         il += int'(illegal); ad += int'(addr_sel); hl += int'(halted);
         if (reg_we && wb_sel) rl++;
         if (pc_we && pc_sel == 2'd2) pj++;
         if (pc_we && pc_sel == 2'd1) pb++;
         if (i >= v.f + 2) begin
            if (alu_sel != v.alu) alu_bad++;
            if (alu_src_b != v.srcb) srcb_bad++;
         end
         if (i == v.f + 1) begin
            c_ir = ir_q; c_imm = imm_sext; c_jmp = jmp_tgt; c_rd = rd; c_rs1 = rs1; c_rs2 = rs2;
         end
         to_next();
      end
      mem_ready = 1'b0;
      #1;
      chk({tag, ".back_in_fetch"}, int'(mem_re && !addr_sel && !reg_we && !halted), 1);
      chk({tag, ".mem_re"}, re, v.re);
      chk({tag, ".mem_we"}, we, v.we);
      chk({tag, ".reg_we"}, rw, v.rw);
      chk({tag, ".reg_we_wbmem"}, rl, v.rl);
      chk({tag, ".pc_we"}, pc, v.pc);
      chk({tag, ".pc_jump"}, pj, v.pj);
      chk({tag, ".pc_branch"}, pb, v.pb);
      chk({tag, ".illegal"}, il, v.ill);
      chk({tag, ".addr_sel"}, ad, v.ad);
      chk({tag, ".halted"}, hl, 0);
      chk({tag, ".alu_sel_bad"}, alu_bad, 0);
      chk({tag, ".alu_src_b_bad"}, srcb_bad, 0);
      chk({tag, ".ir_q"}, int'(c_ir), int'(v.instr));
      chk({tag, ".imm_sext"}, int'(c_imm), int'(v.imm));
      chk({tag, ".jmp_tgt"}, int'(c_jmp), int'(v.jmp));
      chk({tag, ".regs"}, int'({c_rd, c_rs1, c_rs2}), int'({v.rd, v.rs1, v.rs2}));
   endtask

   vec_t table_v[9];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //           instr     zf    f  m  lat re we rw rl pc pj pb il ad alu   srcb  rd    rs1   rs2   imm       jmp
      table_v[0] = '{16'h1A98, 1'b0, 0, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'd1, 1'b0, 3'd5, 3'd2, 3'd3, 16'h0018, 16'h0A98};
      table_v[1] = '{16'h8283, 1'b0, 0, 2, 7, 4, 0, 1, 1, 1, 0, 0, 0, 3, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 16'h0003, 16'h0283};
      table_v[2] = '{16'h9283, 1'b0, 1, 1, 6, 2, 2, 0, 0, 1, 0, 0, 0, 2, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 16'h0003, 16'h0283};
      table_v[3] = '{16'hA07F, 1'b1, 0, 0, 3, 1, 0, 0, 0, 2, 0, 1, 0, 0, 3'd1, 1'b0, 3'd0, 3'd1, 3'd7, 16'hFFFF, 16'h007F};
      table_v[4] = '{16'hA07F, 1'b0, 2, 0, 5, 3, 0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 1'b0, 3'd0, 3'd1, 3'd7, 16'hFFFF, 16'h007F};
      table_v[5] = '{16'hB123, 1'b0, 0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 3'd0, 1'b0, 3'd0, 3'd4, 3'd4, 16'hFFE3, 16'h0123};
      table_v[6] = '{16'hC000, 1'b0, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0, 1, 0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000};
      table_v[7] = '{16'h7FFF, 1'b1, 0, 0, 4, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3'd7, 1'b0, 3'd7, 3'd7, 3'd7, 16'hFFFF, 16'h0FFF};
      table_v[8] = '{16'h8283, 1'b0, 0, 0, 5, 2, 0, 1, 1, 1, 0, 0, 0, 1, 3'd0, 1'b1, 3'd1, 3'd2, 3'd0, 16'h0003, 16'h0283};

      rst = 1'b1; mem_ready = 1'b0; instr_in = 16'h0; zf = 1'b0;
      to_next();
      to_next();
      @(negedge clk);
      chk("reset.ir_q", int'(ir_q), 0);
      chk("reset.halted", int'(halted), 0);
      chk("reset.strobes", int'({pc_we, mem_re, mem_we, reg_we, illegal}), 0);
      to_next();
      rst = 1'b0;
      @(negedge clk);
      chk("reset.fetch", int'({mem_re, addr_sel, pc_we}), 3'b100);
      to_next();

      for (int i = 0; i < 9; i++) run_vec($sformatf("table%0d", i), table_v[i]);

      // Reset while a store is stalled in MEM; also rst together with mem_ready in FETCH
      instr_in = 16'h9283; mem_ready = 1'b1;
      to_next();
      mem_ready = 1'b0;
      to_next();
      to_next();
      @(negedge clk);
      chk("stall.mem_we", int'({mem_we, addr_sel}), 2'b11);
      to_next();
      rst = 1'b1;
      to_next();
      instr_in = 16'h1234; mem_ready = 1'b1;
      @(negedge clk);
      chk("stall_rst.ir_q", int'(ir_q), 0);
      chk("stall_rst.strobes", int'({pc_we, mem_re, mem_we, reg_we, illegal}), 0);
      chk("stall_rst.halted", int'(halted), 0);
      to_next();
      mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_ready.ir_q", int'(ir_q), 0);
      to_next();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_release.fetch", int'({mem_re, addr_sel, mem_we, pc_we}), 4'b1000);
      to_next();

      for (int n = 0; n < 150; n++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if (ins[15:12] == 4'hF) ins[15:12] = 4'($urandom_range(0, 14));
         run_vec($sformatf("rand%0d", n),
                 model(ins, 1'($urandom % 2), int'($urandom_range(0, 2)), int'($urandom_range(0, 3))));
      end

      // HALT: sticky with all strobes low until reset
      instr_in = 16'hF000; mem_ready = 1'b1;
      to_next();
      @(negedge clk);
      chk("halt.decode", int'({halted, illegal, pc_we}), 0);
      to_next();
      for (int i = 0; i < 10; i++) begin
         mem_ready = 1'($urandom % 2); instr_in = 16'($urandom); zf = 1'($urandom % 2);
         @(negedge clk);
         chk($sformatf("halt%0d.halted", i), int'(halted), 1);
         chk($sformatf("halt%0d.strobes", i), int'({pc_we, mem_re, mem_we, reg_we, illegal}), 0);
         to_next();
      end
      rst = 1'b1;
      to_next();
      @(negedge clk);
      chk("halt_rst.halted", int'(halted), 0);
      chk("halt_rst.ir_q", int'(ir_q), 0);
      to_next();
      rst = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("halt_rst.fetch", int'({mem_re, addr_sel, halted}), 3'b100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_unit.md
CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- instr_in  input  16  memory read data (instruction)
- mem_ready  input  1  memory access complete this cycle
- zf  input  1  ALU zero flag (ZF)
- ir_q  output  16  latched instruction register
- rd, rs1, rs2  output  3 each  register indices ir[11:9], ir[8:6], ir[5:3]
- imm_sext  output  16  ir[5:0] sign-extended
- jmp_tgt  output  16  ir[11:0] zero-extended
- alu_sel  output  3  ALU_Sel to ALU
- alu_src_b  output  1  0=register B, 1=imm_sext
- pc_we  output  1  PC write strobe
- pc_sel  output  2  0=PC+1, 1=PC+1+imm_sext, 2=jmp_tgt
- addr_sel  output  1  0=PC addresses memory, 1=ALU_Out
- mem_re, mem_we  output  1 each  memory read/write strobes
- reg_we  output  1  register-file write strobe
- wb_sel  output  1  0=ALU_Out, 1=memory data
- illegal  output  1  one-cycle pulse on undefined opcode
- halted  output  1  high in HALT state

Function
REQ-003 SHALL decode opcode ir[15:12]: 0000-0111 R-type (alu_sel=opcode[2:0]); 1000 LD; 1001 ST; 1010 BEQ; 1011 JMP; 1111 HALT; 1100-1110 illegal.
REQ-004 SHALL implement states FETCH, DECODE, EXECUTE, MEM, WB, HALT.
REQ-005 FETCH: addr_sel=0, mem_re=1; on mem_ready: ir_q<=instr_in, pc_we=1, pc_sel=0, ->DECODE; else hold FETCH with pc_we=0.
REQ-006 DECODE: JMP asserts pc_we=1, pc_sel=2, ->FETCH; HALT ->HALT; illegal pulses illegal=1, ->FETCH; all others ->EXECUTE.
REQ-007 EXECUTE: R-type alu_src_b=0 ->WB; LD/ST alu_sel=3'd0 (add), alu_src_b=1 ->MEM; BEQ alu_sel=3'd1 (subtract), alu_src_b=0, pc_sel=1, pc_we=zf ->FETCH.
REQ-008 MEM: addr_sel=1; LD mem_re=1, ST mem_we=1; state held while mem_ready=0; on mem_ready LD ->WB, ST ->FETCH.
REQ-009 WB: reg_we=1 for exactly one cycle; wb_sel=1 for LD, 0 for R-type; ->FETCH.
REQ-010 HALT: all strobes 0, halted=1, remains until rst.
REQ-011 Latency with mem_ready always high: R-type 4 cycles, LD 5, ST 4, BEQ 3, JMP 2, illegal 2.
REQ-012 All strobes (pc_we, mem_re, mem_we, reg_we, illegal) SHALL be 0 in every state/opcode combination not named above.
REQ-013 alu_sel SHALL hold its decoded value throughout EXECUTE, MEM and WB of one instruction.
REQ-014 mem_we SHALL never be asserted while mem_ready-wait stalls FETCH.

Reset
REQ-015 rst SHALL force state=FETCH, ir_q=16'h0000, halted=0, all strobes 0 on the next rising edge, overriding any state including mid-MEM stall and HALT.
REQ-016 rst asserted concurrently with mem_ready SHALL not load ir_q nor pulse pc_we.

Structure
REQ-017 Shared package ctrl_pkg SHALL hold the state enum, 4-bit opcode constants and 3-bit ALU_Sel constants (ADD=0, SUB=1).
REQ-018 Field extraction and opcode classification SHALL be one combinational sub-module, instr_decode; the FSM and ir_q register remain in ctrl_unit.

Verification
REQ-019 R-type: instr_in=16'h1A98 (opcode 0001), mem_ready=1 -> ir_q=16'h1A98, rd=5, rs1=2, rs2=3, alu_sel=1, reg_we pulse in cycle 4, wb_sel=0.
REQ-020 LD with memory stall: instr_in=16'h8283 (imm=3), mem_ready low 2 cycles in MEM -> mem_re held 3 cycles, imm_sext=16'h0003, reg_we=1 with wb_sel=1 only after mem_ready.
REQ-021 BEQ: instr_in=16'hA07F (imm=-1) with zf=1 -> pc_we=1, pc_sel=1, imm_sext=16'hFFFF; repeat with zf=0 -> pc_we=0.
REQ-022 JMP then HALT: 16'hB123 -> pc_sel=2, jmp_tgt=16'h0123 in DECODE; then 16'hF000 -> halted=1 and all strobes 0 for 10 cycles.
REQ-023 Illegal and reset: 16'hC000 -> illegal pulse exactly 1 cycle, back to FETCH; rst asserted during MEM stall -> next cycle state FETCH, ir_q=0, mem_we=0.
